// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
// Latency: n/a (types only).
// Backpressure: n/a.
package serial_subtractor_4bit_pkg;

    // FSM state encoding shared with the other arithmetic blocks
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_4bit_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow out.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow generated/propagated by this bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial subtractor: {borrow_out,diff} = a - b - borrow_in, one bit per clock, LSB first.
// Latency: WIDTH+1 edges from accepted start to the done pulse; busy for WIDTH cycles.
// Backpressure: start is ignored while busy; accepted only in IDLE or in the DONE cycle.
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    import serial_subtractor_4bit_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);
    // Count value seen on the final shift edge
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic             brw;
    logic             d_bit;
    logic             bout_bit;

    // Single shared bit-slice working on the current LSBs and the stored borrow
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // Control FSM, operand/result shifting and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            count      <= '0;
            a_sr       <= '0;
            b_sr       <= '0;
            res        <= '0;
            brw        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= borrow_in;
                        res   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    brw   <= bout_bit;
                    res   <= {d_bit, res[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        // Last bit: publish the fully assembled result this edge
                        diff       <= {d_bit, res[WIDTH-1:1]};
                        borrow_out <= bout_bit;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Back-to-back request: skip IDLE entirely
                        a_sr  <= a;
                        b_sr  <= b;
                        brw   <= borrow_in;
                        res   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= ST_SHIFT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Bench for serial_subtractor_4bit: scoreboarded operations, start-while-busy,
// back-to-back start, and asynchronous reset in the middle of an operation.
// Inputs change on the falling edge or just after the rising edge; outputs are read on falling edges.
module tb_serial_subtractor_4bit;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    int total = 0;
    int bad   = 0;
    logic [WIDTH:0] sb[$];

    serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    // Drive a request and record its expected {borrow_out,diff}
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tbin);
        a         = ta;
        b         = tb_v;
        borrow_in = tbin;
        start     = 1'b1;
        sb.push_back((WIDTH+1)'({1'b0, ta}) - (WIDTH+1)'({1'b0, tb_v}) - (WIDTH+1)'(tbin));
    endtask

    // Step clock until done is seen (bounded); start is dropped after the first edge
    task automatic wait_done(output int edges, output int busy_cycles, output bit seen);
        edges = 0;
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            edges++;
            #1 start = 1'b0;
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (diff !== '0) begin bad++; $display("FAIL reset_diff: got %0d want 0", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL reset_borrow: got %b want 0", borrow_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tbin);
        int edges, bcyc;
        bit seen;
        logic [WIDTH:0] exp;
        issue(ta, tb_v, tbin);
        wait_done(edges, bcyc, seen);
        total++; if (!seen) begin bad++; $display("FAIL basic_timeout: a=%0d b=%0d no done", ta, tb_v); end
        total++; if (edges != WIDTH + 1) begin bad++; $display("FAIL basic_latency: got %0d want %0d", edges, WIDTH + 1); end
        total++; if (bcyc != WIDTH) begin bad++; $display("FAIL basic_busy_cycles: got %0d want %0d", bcyc, WIDTH); end
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            total++;
            if ({borrow_out, diff} !== exp) begin
                bad++;
                $display("FAIL basic_result a=%0d b=%0d bin=%0d: got %b want %b", ta, tb_v, tbin, {borrow_out, diff}, exp);
            end
        end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_start_while_busy;
        int bcyc;
        logic [WIDTH:0] exp;
        bcyc = 0;
        issue(4'd3, 4'd6, 1'b0);
        @(posedge clk);
        #1 a = 4'd15; b = 4'd0; borrow_in = 1'b1;   // start stays high
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (busy) bcyc++;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL busy_early_done: cycle %0d got %b want 0", i, done); end
            @(posedge clk);
        end
        #1 start = 1'b0;
        @(negedge clk);
        total++; if (bcyc != WIDTH) begin bad++; $display("FAIL busy_cycles_held: got %0d want %0d", bcyc, WIDTH); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_done: got %b want 1", done); end
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            total++;
            if ({borrow_out, diff} !== exp) begin
                bad++;
                $display("FAIL busy_result: got %b want %b", {borrow_out, diff}, exp);
            end
        end
        @(negedge clk);
        total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL busy_single_pulse: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_back_to_back;
        int edges, bcyc;
        bit seen;
        logic [WIDTH:0] exp;
        issue(4'd1, 4'd1, 1'b1);
        wait_done(edges, bcyc, seen);
        total++; if (!seen) begin bad++; $display("FAIL b2b_first_timeout: no done"); end
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            total++;
            if ({borrow_out, diff} !== exp) begin bad++; $display("FAIL b2b_first_result: got %b want %b", {borrow_out, diff}, exp); end
        end
        // Still inside the DONE cycle: request the next operation
        issue(4'd7, 4'd2, 1'b0);
        wait_done(edges, bcyc, seen);
        total++; if (!seen) begin bad++; $display("FAIL b2b_second_timeout: no done"); end
        total++; if (edges != WIDTH + 1) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", edges, WIDTH + 1); end
        total++; if (bcyc != WIDTH) begin bad++; $display("FAIL b2b_busy_cycles: got %0d want %0d", bcyc, WIDTH); end
        if (sb.size() > 0) begin
            exp = sb.pop_front();
            total++;
            if ({borrow_out, diff} !== exp) begin bad++; $display("FAIL b2b_second_result: got %b want %b", {borrow_out, diff}, exp); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        saw_done = 1'b0;
        a = 4'd2; b = 4'd9; borrow_in = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
        total++; if (diff !== '0) begin bad++; $display("FAIL midrst_diff: got %0d want 0", diff); end
        total++; if (borrow_out !== 1'b0) begin bad++; $display("FAIL midrst_borrow: got %b want 0", borrow_out); end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        total++; if (saw_done) begin bad++; $display("FAIL midrst_activity: got done/busy after reset want none"); end
    endtask

    initial begin
        test_reset;
        test_basic(4'd0, 4'd0, 1'b0);
        test_basic(4'd3, 4'd6, 1'b0);
        test_basic(4'd1, 4'd1, 1'b1);
        test_basic(4'd9, 4'd4, 1'b0);
        test_basic(4'd15, 4'd15, 1'b1);
        test_basic(4'd0, 4'd15, 1'b0);
        for (int i = 0; i < 6; i++) begin
            test_basic(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid;
        total++; if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
